// File: rtl/psr_pkg.sv
// Shared types for the parametrised bidirectional shift register: operation
// modes, burst FSM states and the burst-eligibility helper.
package psr_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHU  = 3'b001,
        MODE_SHD  = 3'b010,
        MODE_LOAD = 3'b011,
        MODE_ROTU = 3'b100,
        MODE_ROTD = 3'b101,
        MODE_ASHD = 3'b110,
        MODE_CLR  = 3'b111
    } psr_mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } psr_state_e;

    // Only the modes that move bits are worth repeating; hold, load and clear
    // are idempotent, so a burst of them degenerates into a single operation.
    function automatic logic is_burst_mode(input psr_mode_e m);
        return (m == MODE_SHU)  || (m == MODE_SHD) || (m == MODE_ROTU) ||
               (m == MODE_ROTD) || (m == MODE_ASHD);
    endfunction

endpackage

// File: rtl/param_bidir_shift_reg_if.sv
// Control/data bundle of the shift register: the driver side uses the master
// modport, the register itself uses the slave modport.
interface param_bidir_shift_reg_if
    import psr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);

    logic             EN;
    psr_mode_e        MODE;
    logic             DSR;
    logic             DSL;
    logic [WIDTH-1:0] D;
    logic             START;
    logic [CNT_W-1:0] CNT;
    logic [WIDTH-1:0] Q;
    logic             SO_UP;
    logic             SO_DN;
    logic             BUSY;
    logic             DONE;

    modport master (
        output EN, MODE, DSR, DSL, D, START, CNT,
        input  Q, SO_UP, SO_DN, BUSY, DONE
    );

    modport slave (
        input  EN, MODE, DSR, DSL, D, START, CNT,
        output Q, SO_UP, SO_DN, BUSY, DONE
    );

endinterface

// File: rtl/psr_next_state.sv
// Combinational next-value logic of the shift register for one operation,
// given the current contents, the selected mode and the serial/parallel inputs.
module psr_next_state
    import psr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  psr_mode_e        mode,
    input  logic             dsr,
    input  logic             dsl,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q_next
);

    always_comb begin
        q_next = q;
        case (mode)
            MODE_HOLD: q_next = q;
            MODE_SHU:  q_next = {q[WIDTH-2:0], dsr};
            MODE_SHD:  q_next = {dsl, q[WIDTH-1:1]};
            MODE_LOAD: q_next = d;
            MODE_ROTU: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROTD: q_next = {q[0], q[WIDTH-1:1]};
            // Sign bit is replicated so signed values halve correctly.
            MODE_ASHD: q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            MODE_CLR:  q_next = '0;
            default:   q_next = q;
        endcase
    end

endmodule

// File: rtl/param_bidir_shift_reg.sv
// WIDTH-bit bidirectional shift/rotate register with clock enable, serial taps
// and a burst engine that repeats one shift/rotate CNT times (BUSY/DONE).
module param_bidir_shift_reg
    import psr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                  CP,
    input  logic                  CR,
    param_bidir_shift_reg_if.slave bus
);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;
    logic [CNT_W-1:0] remaining;
    psr_mode_e        lmode;
    psr_mode_e        op_mode;
    psr_state_e       state;
    logic             busy;
    logic             done;
    logic             burst_req;

    // During a burst the latched mode drives the datapath; MODE is ignored.
    assign op_mode   = (state == ST_BURST) ? lmode : bus.MODE;
    assign burst_req = (state == ST_IDLE) && bus.START && is_burst_mode(bus.MODE);

    psr_next_state #(
        .WIDTH (WIDTH)
    ) u_next (
        .q      (q),
        .mode   (op_mode),
        .dsr    (bus.DSR),
        .dsl    (bus.DSL),
        .d      (bus.D),
        .q_next (q_next)
    );

    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            q         <= '0;
            remaining <= '0;
            lmode     <= MODE_HOLD;
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (!bus.EN) begin
            // Frozen: a burst that would complete waits for the next enabled edge.
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (burst_req) begin
                        if (bus.CNT != '0) begin
                            q         <= q_next;
                            lmode     <= bus.MODE;
                            remaining <= bus.CNT - CNT_W'(1);
                        end
                        if (bus.CNT <= CNT_W'(1)) begin
                            done <= 1'b1;
                        end else begin
                            state <= ST_BURST;
                            busy  <= 1'b1;
                        end
                    end else begin
                        q <= q_next;
                    end
                end
                ST_BURST: begin
                    q         <= q_next;
                    remaining <= remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Q     = q;
    assign bus.SO_UP = q[WIDTH-1];
    assign bus.SO_DN = q[0];
    assign bus.BUSY  = busy;
    assign bus.DONE  = done;

endmodule

// File: doc/param_bidir_shift_reg.md
Name: param_bidir_shift_reg

Overview:
- WIDTH-bit parametrised successor of the team's 4-bit bidirectional shift register.
- Adds rotate, arithmetic-shift and synchronous-clear modes, plus a clock enable and serial taps at both ends.
- Adds a burst engine that repeats one shift/rotate operation a programmed number of times, with BUSY/DONE handshake.
- Used as the serial/parallel converter and barrel-stepper in datapath front ends.

Parameters:
- WIDTH, 8, register width in bits; must be >= 2.
- CNT_W, 4, width of burst count input; max burst length is 2^CNT_W-1.

Ports:
- CP  input  1  clock, rising edge.
- CR  input  1  asynchronous active-low reset (clear).
- EN  input  1  clock enable; 0 freezes all state (Q, counter, BUSY), DONE forced 0.
- MODE  input  3  operation select (encoding below).
- DSR  input  1  serial input entering bit 0 on shift-up.
- DSL  input  1  serial input entering bit WIDTH-1 on shift-down.
- D  input  WIDTH  parallel load data.
- START  input  1  burst request, sampled when EN=1 and BUSY=0.
- CNT  input  CNT_W  burst length, sampled with START.
- Q  output  WIDTH  register contents.
- SO_UP  output  1  Q[WIDTH-1], combinational.
- SO_DN  output  1  Q[0], combinational.
- BUSY  output  1  burst in progress.
- DONE  output  1  one-cycle pulse when a burst completes.

Behaviour:
- Reset: CR=0 asynchronously forces Q=0, BUSY=0, DONE=0, internal remaining-count=0 and latched mode=000. CR has priority over everything, including mid-burst; the burst is abandoned and no DONE is issued.
- MODE encoding, applied once per enabled edge:
  - 000: hold.
  - 001: shift up, Q <= {Q[W-2:0],DSR}.
  - 010: shift down, Q <= {DSL,Q[W-1:1]}.
  - 011: load, Q <= D.
  - 100: rotate up, Q <= {Q[W-2:0],Q[W-1]}.
  - 101: rotate down, Q <= {Q[0],Q[W-1:1]}.
  - 110: arithmetic shift down, Q <= {Q[W-1],Q[W-1:1]}.
  - 111: synchronous clear, Q <= 0.
- Idle (BUSY=0), EN=1, START=0: MODE applied on the edge; latency 1 clock.
- Burst start: idle, EN=1, START=1, MODE in {001,010,100,101,110}, CNT=k.
  - k>=1: the start edge performs operation #1, latches MODE, sets remaining=k-1, and sets BUSY=1 if k>=2.
  - k=1: no BUSY; DONE=1 on the edge after the start edge's update, i.e. DONE is high in the cycle following the single shift.
- While BUSY=1 with EN=1: each edge applies the latched mode with the live DSR/DSL and decrements remaining.
  - On the edge where remaining goes 1->0, BUSY drops and DONE is asserted for exactly one cycle.
  - Total shifts = k; BUSY is high for k-1 cycles.
- START with CNT=0: no shift, BUSY stays 0, DONE pulses the next cycle.
- START with MODE in {000,011,111}: START ignored; MODE applied as a single op; no DONE.
- While BUSY: MODE, START, CNT and D are ignored.
- EN=0 mid-burst: everything holds, including remaining; burst resumes when EN returns. A pending DONE is deferred until the enabled edge that completes the burst.
- DONE is registered and never high while BUSY=1. Back-to-back START is accepted the cycle DONE is high (BUSY=0).
- SO_UP/SO_DN follow Q combinationally; no extra latency.

Decomposition:
- Shared package psr_pkg:
  - mode enum psr_mode_e (MODE_HOLD, MODE_SHU, MODE_SHD, MODE_LOAD, MODE_ROTU, MODE_ROTD, MODE_ASHD, MODE_CLR);
  - function is_burst_mode().
- One sub-module, psr_next_state: combinational next-Q from (Q, mode, DSR, DSL, D). The top instantiates it and holds the burst counter/FSM (IDLE, BURST).

Test Plan (WIDTH=8, CNT_W=4):
- Reset: CR pulse low mid-cycle with Q=8'hA5, BUSY=1 -> Q=0, BUSY=0 immediately, no DONE.
- Single ops:
  - load D=8'h81, then MODE=100 -> Q=8'h03;
  - MODE=101 from 8'h03 -> 8'h81;
  - MODE=110 from 8'h81 -> 8'hC0;
  - MODE=111 -> 8'h00.
- Shift, serial: Q=8'h00, MODE=001, DSR=1 for 3 edges -> Q=8'h07, SO_DN=1, SO_UP=0. MODE=010, DSL=0 once -> 8'h03.
- Burst:
  - load 8'h01, START with MODE=100, CNT=5 -> BUSY high 4 cycles, Q=8'h20 when DONE pulses one cycle;
  - MODE changed to 011 during burst has no effect.
- Burst with EN gap: load 8'h80, CNT=3, MODE=010, DSL=0; drop EN for 2 cycles after first shift -> Q holds 8'h40 during gap, ends 8'h10, exactly 3 shifts, one DONE.
- Edge counts:
  - CNT=0 START -> DONE next cycle, Q unchanged;
  - CNT=15 MODE=101 from 8'h01 -> Q=8'h02 (15 mod 8 = 7 rotates down);
  - START with MODE=011 -> loads D, no DONE.
